// File: rtl/decode_issue.sv
// Decode/issue stage for the 16-bit, 8-register core: decodes fields, reads operands,
// tracks outstanding destination writes in a scoreboard and issues over valid/ready.
module decode_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [2:0]  rf_rs1,
    output logic [2:0]  rf_rs2,
    input  logic [15:0] rf_data_rs1,
    input  logic [15:0] rf_data_rs2,
    input  logic        wb_valid,
    input  logic [2:0]  wb_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [2:0]  out_rd,
    output logic        out_wen,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_imm,
    output logic        out_illegal,
    output logic [7:0]  busy_regs
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext3(input logic [2:0] v);
        return {{13{v[2]}}, v};
    endfunction

    logic [3:0]  dec_op;
    logic [2:0]  dec_rd;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        dec_wen;
    logic [15:0] dec_imm;
    logic        dec_illegal;
    logic        hazard;
    logic        accept;

    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_op_q, out_op_d;
    logic [2:0]  out_rd_q, out_rd_d;
    logic        out_wen_q, out_wen_d;
    logic [15:0] out_a_q, out_a_d;
    logic [15:0] out_b_q, out_b_d;
    logic [15:0] out_imm_q, out_imm_d;
    logic        out_illegal_q, out_illegal_d;
    logic [7:0]  busy_q, busy_d;

    assign dec_op = in_instr[15:12];
    assign dec_rd = in_instr[11:9];
    assign rf_rs1 = in_instr[8:6];
    assign rf_rs2 = in_instr[5:3];

    always_comb begin
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_wen     = 1'b0;
        dec_imm     = 16'h0000;
        dec_illegal = 1'b0;
        case (dec_op) inside
            OP_NOP: begin
            end
            [4'h1:4'h7]: begin
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_wen     = 1'b1;
            end
            OP_ADDI: begin
                dec_use_rs1 = 1'b1;
                dec_wen     = 1'b1;
                dec_imm     = sext6(in_instr[5:0]);
            end
            OP_LD: begin
                dec_use_rs1 = 1'b1;
                dec_wen     = 1'b1;
                dec_imm     = sext3(in_instr[2:0]);
            end
            OP_ST, OP_BEQ: begin
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_imm     = sext3(in_instr[2:0]);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Hazards look only at the registered scoreboard, so a writeback this cycle
    // releases a stalled instruction on the following edge.
    assign hazard = (dec_use_rs1 && busy_q[rf_rs1]) ||
                    (dec_use_rs2 && busy_q[rf_rs2]) ||
                    (dec_wen     && busy_q[dec_rd]);

    assign in_ready = (!out_valid_q || out_ready) && !(in_valid && hazard);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_rd_d      = out_rd_q;
        out_wen_d     = out_wen_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_imm_d     = out_imm_q;
        out_illegal_d = out_illegal_q;
        busy_d        = busy_q;

        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end

        if (accept) begin
            out_valid_d   = 1'b1;
            out_op_d      = dec_op;
            out_rd_d      = dec_rd;
            out_wen_d     = dec_wen;
            out_a_d       = dec_use_rs1 ? rf_data_rs1 : 16'h0000;
            out_b_d       = dec_use_rs2 ? rf_data_rs2 : 16'h0000;
            out_imm_d     = dec_imm;
            out_illegal_d = dec_illegal;
            if (dec_wen) begin
                busy_d[dec_rd] = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_op_q      <= 4'h0;
            out_rd_q      <= 3'h0;
            out_wen_q     <= 1'b0;
            out_a_q       <= 16'h0000;
            out_b_q       <= 16'h0000;
            out_imm_q     <= 16'h0000;
            out_illegal_q <= 1'b0;
            busy_q        <= 8'h00;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_rd_q      <= out_rd_d;
            out_wen_q     <= out_wen_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_imm_q     <= out_imm_d;
            out_illegal_q <= out_illegal_d;
            busy_q        <= busy_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_rd      = out_rd_q;
    assign out_wen     = out_wen_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_imm     = out_imm_q;
    assign out_illegal = out_illegal_q;
    assign busy_regs   = busy_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus randomized traffic against a reference model.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [2:0]  rf_rs1, rf_rs2;
    logic [15:0] rf_data_rs1, rf_data_rs2;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_rd;
    logic        out_wen;
    logic [15:0] out_a, out_b, out_imm;
    logic        out_illegal;
    logic [7:0]  busy_regs;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  m_busy;
    logic        m_vld;
    logic [3:0]  m_op;
    logic [2:0]  m_rd;
    logic        m_wen;
    logic [15:0] m_a, m_b, m_imm;
    logic        m_ill;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_wen(out_wen), .out_a(out_a), .out_b(out_b),
        .out_imm(out_imm), .out_illegal(out_illegal), .busy_regs(busy_regs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Instruction semantics written from the ISA table, with plain integer sign handling.
    task automatic model_decode(input logic [15:0] ins, output logic r1, output logic r2,
                                output logic wr, output logic [15:0] imm, output logic ill);
        int op, v;
        op  = int'(ins[15:12]);
        ill = (op >= 12);
        r1  = (op >= 1 && op <= 11);
        r2  = (op >= 1 && op <= 7) || op == 10 || op == 11;
        wr  = (op >= 1 && op <= 9);
        v   = 0;
        if (op == 8) begin
            v = int'(ins[5:0]);
            if (v >= 32) v = v - 64;
        end else if (op >= 9 && op <= 11) begin
            v = int'(ins[2:0]);
            if (v >= 4) v = v - 8;
        end
        imm = 16'(v);
    endtask

    task automatic model_reset();
        m_busy = 8'h00; m_vld = 1'b0; m_op = 4'h0; m_rd = 3'h0; m_wen = 1'b0;
        m_a = 16'h0; m_b = 16'h0; m_imm = 16'h0; m_ill = 1'b0;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out_op", 32'(out_op), 32'(m_op));
        check("out_rd", 32'(out_rd), 32'(m_rd));
        check("out_wen", 32'(out_wen), 32'(m_wen));
        check("out_a", 32'(out_a), 32'(m_a));
        check("out_b", 32'(out_b), 32'(m_b));
        check("out_imm", 32'(out_imm), 32'(m_imm));
        check("out_illegal", 32'(out_illegal), 32'(m_ill));
        check("busy_regs", 32'(busy_regs), 32'(m_busy));
    endtask

    // One clock: drive at negedge, check combinational outputs, update model at posedge.
    task automatic cycle(input logic v, input logic [15:0] ins, input logic ordy,
                         input logic wv, input logic [2:0] wr, input logic [15:0] d1,
                         input logic [15:0] d2);
        logic r1, r2, w, ill, hz, exp_rdy;
        logic [15:0] imm;
        @(negedge clk);
        in_valid = v; in_instr = ins; out_ready = ordy; wb_valid = wv; wb_rd = wr;
        rf_data_rs1 = d1; rf_data_rs2 = d2;
        #1;
        model_decode(ins, r1, r2, w, imm, ill);
        hz = (r1 && m_busy[ins[8:6]]) || (r2 && m_busy[ins[5:3]]) || (w && m_busy[ins[11:9]]);
        exp_rdy = (!m_vld || ordy) && !(v && hz);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("rf_rs1", 32'(rf_rs1), 32'(ins[8:6]));
        check("rf_rs2", 32'(rf_rs2), 32'(ins[5:3]));
        @(posedge clk);
        if (wv) m_busy[wr] = 1'b0;
        if (v && exp_rdy) begin
            m_vld = 1'b1; m_op = ins[15:12]; m_rd = ins[11:9]; m_wen = w;
            m_a = r1 ? d1 : 16'h0; m_b = r2 ? d2 : 16'h0; m_imm = imm; m_ill = ill;
            if (w) m_busy[ins[11:9]] = 1'b1;
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy_regs), 32'd0);
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] pick;
        logic [2:0] wr;
        rst = 1'b0; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = 3'h0; rf_data_rs1 = 16'h0; rf_data_rs2 = 16'h0;
        model_reset();
        #2;
        apply_reset();

        // ADD r3,r1,r2
        cycle(1, 16'h1650, 1, 0, 0, 16'h0005, 16'h0007);
        check("add_op", 32'(out_op), 32'd1);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_wen", 32'(out_wen), 32'd1);
        check("add_a", 32'(out_a), 32'h0005);
        check("add_b", 32'(out_b), 32'h0007);
        check("add_busy", 32'(busy_regs), 32'h08);

        // RAW: ADDI r4,r3,-1 waits for r3 writeback
        cycle(1, 16'h88FF, 1, 0, 0, 16'h1111, 16'h2222);
        cycle(1, 16'h88FF, 1, 0, 0, 16'h1111, 16'h2222);
        cycle(1, 16'h88FF, 1, 1, 3, 16'h1111, 16'h2222);
        cycle(1, 16'h88FF, 1, 0, 0, 16'h1234, 16'h2222);
        check("addi_imm", 32'(out_imm), 32'hFFFF);
        check("addi_busy", 32'(busy_regs), 32'h10);

        // WAW: ADD r3,r5,r6 behind a pending r3 write
        cycle(1, 16'h1650, 1, 0, 0, 16'h0001, 16'h0002);
        cycle(1, 16'h1770, 1, 0, 0, 16'h0003, 16'h0004);
        cycle(1, 16'h1770, 1, 0, 0, 16'h0003, 16'h0004);
        cycle(1, 16'h1770, 1, 1, 3, 16'h0003, 16'h0004);
        cycle(1, 16'h1770, 1, 0, 0, 16'h0003, 16'h0004);

        // Backpressure for three cycles, then release accepts a NOP on the same edge
        cycle(0, 16'h0000, 0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 16'h0000, 0, 0, 0, 16'hAAAA, 16'h5555);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        cycle(1, 16'h0000, 1, 0, 0, 16'h0, 16'h0);

        // Drain scoreboard, including a writeback to an idle register
        cycle(0, 16'h0000, 1, 1, 3, 16'h0, 16'h0);
        cycle(0, 16'h0000, 1, 1, 4, 16'h0, 16'h0);
        cycle(0, 16'h0000, 1, 1, 7, 16'h0, 16'h0);

        // Illegal and store
        cycle(1, 16'hC123, 1, 0, 0, 16'h9999, 16'h8888);
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_wen", 32'(out_wen), 32'd0);
        cycle(1, 16'hA0CF, 1, 0, 0, 16'h0042, 16'h0043);
        check("st_wen", 32'(out_wen), 32'd0);
        check("st_imm", 32'(out_imm), 32'hFFFF);
        check("st_busy", 32'(busy_regs), 32'h00);

        // Reset while stalled on a pending r3
        cycle(1, 16'h1650, 1, 0, 0, 16'h0005, 16'h0007);
        cycle(1, 16'h1650, 1, 0, 0, 16'h0005, 16'h0007);
        apply_reset();
        cycle(1, 16'h1650, 1, 0, 0, 16'h0005, 16'h0007);
        check("post_rst_busy", 32'(busy_regs), 32'h08);

        // Randomized traffic; writebacks target a busy register most of the time
        for (int n = 0; n < 600; n++) begin
            pick = m_busy;
            wr = 3'($urandom_range(0, 7));
            if (pick != 8'h00 && ($urandom_range(0, 3) != 0)) begin
                while (!pick[wr]) wr = 3'($urandom_range(0, 7));
            end
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), wr, 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
